// File: rtl/i2s_pkg.sv
// Shared constants and width helpers for the I2S/TDM transmitter.
// JUSTIFY_I2S / JUSTIFY_LEFT select the MSB position relative to the WS edge.
// clog2 / width_for size counters and FIFO pointers from module parameters.
package i2s_pkg;

  localparam int unsigned JUSTIFY_I2S  = 0;
  localparam int unsigned JUSTIFY_LEFT = 1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..count-1, never narrower than one bit.
  function automatic int unsigned width_for(input int unsigned count);
    return (clog2(count) == 0) ? 1 : clog2(count);
  endfunction

  // Bit counter spans one whole frame of slots.
  function automatic int unsigned bit_cnt_width(input int unsigned channels,
                                                input int unsigned slot_w);
    return width_for(channels * slot_w);
  endfunction

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO, WIDTH bits wide and DEPTH (power of 2, >= 2) deep.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data
// (first-word fall-through), full, empty. Push and pop may share a cycle;
// a push while full or a pop while empty is ignored.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = fifo_ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_tx_multi.sv
// Buffered I2S / TDM serial audio transmitter.
// Ports: MasterCLK (sole clock), Reset (sync, active-high), InputData/InputValid/
// InputReady (frame push, channel 0 in the LSB field), I2S_CLK/I2S_WS/I2S_DATA
// (codec pins), SyncCLK (pulse per frame load), Underrun (pulse when a load
// finds the FIFO empty).
// Build option: I2S_TX_UNDERRUN_REPEAT_EN repeats the last popped frame on
// underrun; without it an underrun transmits a zero frame.
module i2s_tx_multi
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCK_DIV    = 4,
  parameter int unsigned JUSTIFY    = 0
) (
  input  logic                         MasterCLK,
  input  logic                         Reset,
  input  logic [DATA_W*CHANNELS-1:0]   InputData,
  input  logic                         InputValid,
  output logic                         InputReady,
  output logic                         I2S_CLK,
  output logic                         I2S_WS,
  output logic                         I2S_DATA,
  output logic                         SyncCLK,
  output logic                         Underrun
);

  localparam int unsigned FRAME_W    = DATA_W * CHANNELS;
  localparam int unsigned FRAME_BITS = CHANNELS * SLOT_W;
  localparam int unsigned BIT_W      = bit_cnt_width(CHANNELS, SLOT_W);
  localparam int unsigned DIV_W      = width_for(SCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] load_bits;
  logic [FRAME_W-1:0]    fifo_dout;
  logic [FRAME_W-1:0]    load_frame;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rst_done;
  logic                  push;
  logic                  fall_tick;
  logic                  frame_load;
  logic                  ws_next;

  assign InputReady = rst_done && !fifo_full;
  assign push       = InputValid && InputReady;
  assign fall_tick  = (div_cnt == DIV_LAST) && I2S_CLK;
  assign frame_load = fall_tick && (bit_cnt == '0);

  i2s_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (MasterCLK),
    .rst       (Reset),
    .push      (push),
    .push_data (InputData),
    .pop       (frame_load),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0] last_frame;

  always_ff @(posedge MasterCLK) begin
    if (Reset)                          last_frame <= '0;
    else if (frame_load && !fifo_empty) last_frame <= fifo_dout;
  end

  assign load_frame = fifo_empty ? last_frame : fifo_dout;
`else
  assign load_frame = fifo_empty ? '0 : fifo_dout;
`endif

  // Lay the frame out in wire order: bit FRAME_BITS-1 is the first bit sent,
  // each slot is the sample MSB-first followed by zero padding.
  always_comb begin
    load_bits = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned b = 0; b < DATA_W; b++) begin
        load_bits[FRAME_BITS-1-c*SLOT_W-b] = load_frame[c*DATA_W+DATA_W-1-b];
      end
    end
  end

  always_comb begin
    if (CHANNELS == 2) ws_next = (bit_cnt >= SLOT_START);
    else               ws_next = (bit_cnt == '0);
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      rst_done <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      I2S_CLK  <= 1'b0;
      I2S_WS   <= 1'b0;
      I2S_DATA <= 1'b0;
      SyncCLK  <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      SyncCLK  <= frame_load;
      Underrun <= frame_load && fifo_empty;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        I2S_CLK <= ~I2S_CLK;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (fall_tick) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        I2S_WS  <= ws_next;
        if (frame_load) begin
          // Left-justified sends the new MSB at the load; I2S first drains the
          // previous frame's final bit, so the new MSB follows one clock later.
          if (JUSTIFY == JUSTIFY_LEFT) begin
            I2S_DATA <= load_bits[FRAME_BITS-1];
            shreg    <= {load_bits[FRAME_BITS-2:0], 1'b0};
          end else begin
            I2S_DATA <= shreg[FRAME_BITS-1];
            shreg    <= load_bits;
          end
        end else begin
          I2S_DATA <= shreg[FRAME_BITS-1];
          shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_multi.sv
module tb_i2s_tx_multi;

  localparam int MAXW = 192;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            sel;
  logic [MAXW-1:0] in_bus;

  logic a_ready, a_clk, a_ws, a_data, a_sync, a_urun;
  logic b_ready, b_clk, b_ws, b_data, b_sync, b_urun;
  logic obs_ready, obs_clk, obs_ws, obs_data, obs_sync, obs_urun;

  always #5 clk = ~clk;

  // Stereo I2S, default parameters.
  i2s_tx_multi #(
    .DATA_W(24), .SLOT_W(32), .CHANNELS(2), .FIFO_DEPTH(4), .SCK_DIV(4), .JUSTIFY(0)
  ) dut_a (
    .MasterCLK(clk), .Reset(rst), .InputData(in_bus[47:0]), .InputValid(valid && !sel),
    .InputReady(a_ready), .I2S_CLK(a_clk), .I2S_WS(a_ws), .I2S_DATA(a_data),
    .SyncCLK(a_sync), .Underrun(a_urun)
  );

  // 8-channel TDM, left-justified, fastest bit clock.
  i2s_tx_multi #(
    .DATA_W(24), .SLOT_W(32), .CHANNELS(8), .FIFO_DEPTH(4), .SCK_DIV(1), .JUSTIFY(1)
  ) dut_b (
    .MasterCLK(clk), .Reset(rst), .InputData(in_bus), .InputValid(valid && sel),
    .InputReady(b_ready), .I2S_CLK(b_clk), .I2S_WS(b_ws), .I2S_DATA(b_data),
    .SyncCLK(b_sync), .Underrun(b_urun)
  );

  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_clk   = sel ? b_clk   : a_clk;
  assign obs_ws    = sel ? b_ws    : a_ws;
  assign obs_data  = sel ? b_data  : a_data;
  assign obs_sync  = sel ? b_sync  : a_sync;
  assign obs_urun  = sel ? b_urun  : a_urun;

  // Reference model state.
  int cfg_dw, cfg_slot, cfg_ch, cfg_div, cfg_just, cfg_depth, cfg_n;
  logic [MAXW-1:0] q[$];
  logic [MAXW-1:0] cur, prev, last;
  int   cyc;
  int   pushed_cnt;
  logic e_ready, e_clk, e_ws, e_data, e_sync, e_urun;
  logic cap_en;
  logic [63:0] cap;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit at frame position qpos: slot qpos/SLOT_W, sample MSB first, then zero pad.
  function automatic logic fbit(input logic [MAXW-1:0] fr, input int qpos);
    int ch;
    int b;
    ch = qpos / cfg_slot;
    b  = qpos % cfg_slot;
    if (b >= cfg_dw) return 1'b0;
    return fr[ch*cfg_dw + cfg_dw - 1 - b];
  endfunction

  function automatic logic [MAXW-1:0] rand_frame();
    logic [MAXW-1:0] fr;
    fr = '0;
    for (int i = 0; i < cfg_ch; i++) fr[i*24 +: 24] = 24'($urandom);
    return fr;
  endfunction

  task automatic configure(input logic s, input int ch, input int div, input int just);
    sel = s; cfg_dw = 24; cfg_slot = 32; cfg_ch = ch; cfg_div = div;
    cfg_just = just; cfg_depth = 4; cfg_n = ch * 32;
  endtask

  // One MasterCLK cycle: drive inputs, advance the model across the edge,
  // then compare every output half a cycle later.
  task automatic step(input logic r, input logic v, input logic [MAXW-1:0] d);
    logic pushing;
    logic tick;
    int   p;
    rst = r; valid = v; in_bus = d;
    pushing = !r && v && e_ready;
    tick = 1'b0;
    @(posedge clk);
    if (r) begin
      q.delete(); cur = '0; prev = '0; last = '0; cyc = 0;
      e_ready = 0; e_clk = 0; e_ws = 0; e_data = 0; e_sync = 0; e_urun = 0;
    end else begin
      cyc++;
      e_sync = 0; e_urun = 0;
      if (cyc % (2*cfg_div) == 0) begin
        tick = 1'b1;
        p = (cyc / (2*cfg_div) - 1) % cfg_n;
        if (p == 0) begin
          e_sync = 1;
          prev = cur;
          if (q.size() > 0) begin
            cur = q.pop_front();
            last = cur;
          end else begin
            e_urun = 1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            cur = last;
`else
            cur = '0;
`endif
          end
        end
        e_ws = (cfg_ch == 2) ? (p >= cfg_slot) : (p == 0);
        if (cfg_just == 1) e_data = fbit(cur, p);
        else               e_data = (p == 0) ? fbit(prev, cfg_n - 1) : fbit(cur, p - 1);
      end
      if (pushing) begin
        q.push_back(d);
        pushed_cnt++;
      end
      e_clk   = ((cyc / cfg_div) % 2) == 1;
      e_ready = q.size() < cfg_depth;
    end
    @(negedge clk);
    check("ready", 64'(obs_ready), 64'(e_ready));
    check("sck",   64'(obs_clk),   64'(e_clk));
    check("ws",    64'(obs_ws),    64'(e_ws));
    check("data",  64'(obs_data),  64'(e_data));
    check("sync",  64'(obs_sync),  64'(e_sync));
    check("urun",  64'(obs_urun),  64'(e_urun));
    if (cap_en && tick) cap = {cap[62:0], obs_data};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  initial begin
    logic [MAXW-1:0] fr;
    int acc;
    rst = 1'b1; valid = 1'b0; in_bus = '0; cap_en = 1'b0; cap = '0;
    pushed_cnt = 0; e_ready = 0;
    configure(1'b0, 2, 4, 0);

    // Known frame, then underrun for the following frames.
    do_reset(3);
    fr = '0;
    fr[47:0] = {24'h123456, 24'hABCDEF};
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, fr);
    cap_en = 1'b1;
    idle(510);
    cap_en = 1'b0;
    check("frame0_bits", cap, (64'hABCDEF << 39) | (64'h123456 << 7));
    idle(3 * 512);

    // Stall: valid held high, FIFO accepts exactly four frames before the first load.
    do_reset(2);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      if (obs_ready) acc++;
      step(1'b0, 1'b1, rand_frame());
    end
    check("stall_pushes", 64'(acc), 64'd4);
    for (int i = 0; i < 600; i++) step(1'b0, 1'b1, rand_frame());
    idle(5 * 512);

    // Reset at bit 17 of the second frame with three frames still queued.
    do_reset(2);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, rand_frame());
    while (cyc < (64 + 18) * 8) step(1'b0, 1'b0, '0);
    check("queued_at_reset", 64'(q.size()), 64'd3);
    step(1'b1, 1'b0, '0);
    check("fifo_empty_after_reset", 64'(q.size()), 64'd0);
    idle(600);

    // Randomised traffic followed by a drain into underrun.
    for (int i = 0; i < 2500; i++) step(1'b0, ($urandom_range(0, 7) == 0), rand_frame());
    idle(1500);

    // TDM, left-justified, SCK_DIV=1: push eight frames as fast as accepted.
    configure(1'b1, 8, 1, 1);
    do_reset(3);
    pushed_cnt = 0;
    for (int i = 0; i < 6000 && pushed_cnt < 8; i++) step(1'b0, 1'b1, rand_frame());
    check("tdm_pushes", 64'(pushed_cnt), 64'd8);
    idle(2 * 512);
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
